// File: rtl/hack_cpu_seq.sv
// hack_cpu_seq -- multi-cycle sequencer for the Hack CPU.
//
// Holds the architectural A, D and PC registers along with the instruction
// register (IR), the memory data register (MDR) and the ALU result register (R).
// It fetches instructions over a handshaked ROM port and decodes A- and
// C-instructions. It also drives the shared combinational ALU and performs
// data-memory accesses over a handshaked RAM port.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   o_rom_req/addr     instruction fetch request, address = PC
//   i_rom_ack/data     fetch completion and instruction word
//   o_mem_req/we/addr  data memory request, write enable, address = A
//   o_mem_wdata        registered ALU result (R)
//   i_mem_ack/rdata    data access completion and read data
//   o_alu_a/b/ctl      ALU operands (x = D, y = A or MDR) and {zx,nx,zy,ny,f,no}
//   i_alu_res/err      ALU result and unsupported-opcode flag
//   o_pc               current PC
//   o_halted           sticky halt after an ALU error
module hack_cpu_seq #(
    parameter int N  = 16,
    parameter int AW = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_rom_req,
    output logic [AW-1:0] o_rom_addr,
    input  logic          i_rom_ack,
    input  logic [N-1:0]  i_rom_data,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [N-1:0]  o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [N-1:0]  i_mem_rdata,
    output logic [N-1:0]  o_alu_a,
    output logic [N-1:0]  o_alu_b,
    output logic [5:0]    o_alu_ctl,
    input  logic [N-1:0]  i_alu_res,
    input  logic          i_alu_err,
    output logic [AW-1:0] o_pc,
    output logic          o_halted
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] MEMRD  = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEMWR  = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;

    logic [2:0]    state_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  d_reg;
    logic [N-1:0]  ir_reg;
    logic [N-1:0]  mdr_reg;
    logic [N-1:0]  r_reg;
    logic [AW-1:0] pc_reg;
    logic          jump_reg;

    logic [AW-1:0] pc_inc;
    logic          zr;
    logic          ng;
    logic          jump_now;

    // Field positions follow the 16-bit Hack C-instruction layout:
    // [15]=C flag, [12]=a, [11:6]=comp, [5:3]=dest (A,D,M), [2:0]=jump.
    assign pc_inc   = pc_reg + AW'(1);  // wraps naturally at 2^AW
    assign zr       = (i_alu_res == '0);
    assign ng       = i_alu_res[N-1];
    assign jump_now = (ir_reg[2] & ng) | (ir_reg[1] & zr) | (ir_reg[0] & ~ng & ~zr);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= FETCH;
            a_reg     <= '0;
            d_reg     <= '0;
            ir_reg    <= '0;
            mdr_reg   <= '0;
            r_reg     <= '0;
            pc_reg    <= '0;
            jump_reg  <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (i_rom_ack) begin
                        ir_reg    <= i_rom_data;
                        state_reg <= DECODE;
                    end
                end
                DECODE: begin
                    if (!ir_reg[N-1]) begin
                        a_reg     <= {1'b0, ir_reg[N-2:0]};
                        pc_reg    <= pc_inc;
                        state_reg <= FETCH;
                    end else begin
                        state_reg <= ir_reg[12] ? MEMRD : EXEC;
                    end
                end
                MEMRD: begin
                    if (i_mem_ack) begin
                        mdr_reg   <= i_mem_rdata;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    // An ALU error freezes everything, including R, so the
                    // halted machine still shows its pre-fault state.
                    if (i_alu_err) begin
                        state_reg <= HALT;
                    end else begin
                        r_reg     <= i_alu_res;
                        jump_reg  <= jump_now;
                        state_reg <= ir_reg[3] ? MEMWR : WB;
                    end
                end
                MEMWR: begin
                    if (i_mem_ack) begin
                        state_reg <= WB;
                    end
                end
                WB: begin
                    // The jump target reads a_reg before this cycle's update
                    // takes effect, so "A=...;JMP" jumps to the old A.
                    if (ir_reg[5]) a_reg <= r_reg;
                    if (ir_reg[4]) d_reg <= r_reg;
                    pc_reg    <= jump_reg ? a_reg[AW-1:0] : pc_inc;
                    state_reg <= FETCH;
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

    // Requests decode from state. They are also masked by reset so they drop
    // in the very cycle reset is asserted, abandoning any in-flight access.
    assign o_rom_req   = (state_reg == FETCH) & ~i_rst;
    assign o_mem_req   = ((state_reg == MEMRD) | (state_reg == MEMWR)) & ~i_rst;
    assign o_mem_we    = (state_reg == MEMWR) & ~i_rst;
    assign o_rom_addr  = pc_reg;
    assign o_mem_addr  = a_reg[AW-1:0];
    assign o_mem_wdata = r_reg;
    assign o_alu_a     = d_reg;
    assign o_alu_b     = ir_reg[12] ? mdr_reg : a_reg;
    assign o_alu_ctl   = ir_reg[11:6];
    assign o_pc        = pc_reg;
    assign o_halted    = (state_reg == HALT);

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Testbench for hack_cpu_seq. A bench-side ROM/RAM responder provides
// configurable wait states. A Hack ALU model drives the ALU inputs. Memory
// operations are compared against a queue of expected accesses.
module tb_hack_cpu_seq;
    localparam int N  = 16;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic          rom_ack = 1'b0;
    logic [N-1:0]  rom_data = '0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          mem_ack = 1'b0;
    logic [N-1:0]  mem_rdata = '0;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [5:0]    alu_ctl;
    logic [N-1:0]  alu_res;
    logic          alu_err;
    logic [AW-1:0] pc;
    logic          halted;

    hack_cpu_seq #(.N(N), .AW(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_rom_req(rom_req), .o_rom_addr(rom_addr), .i_rom_ack(rom_ack), .i_rom_data(rom_data),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctl(alu_ctl),
        .i_alu_res(alu_res), .i_alu_err(alu_err),
        .o_pc(pc), .o_halted(halted)
    );

    always #5 clk = ~clk;

    // Hack ALU model; comp 100000 is treated as unsupported.
    logic [N-1:0] ax, ay, ao;
    always_comb begin
        ax = alu_ctl[5] ? '0 : alu_a;
        ax = alu_ctl[4] ? ~ax : ax;
        ay = alu_ctl[3] ? '0 : alu_b;
        ay = alu_ctl[2] ? ~ay : ay;
        ao = alu_ctl[1] ? (ax + ay) : (ax & ay);
        ao = alu_ctl[0] ? ~ao : ao;
        alu_res = ao;
        alu_err = (alu_ctl == 6'b100000);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } mem_op_t;
    mem_op_t exp_q[$];

    logic [N-1:0] rom [0:32767];
    logic [N-1:0] ram [0:32767];

    int cyc = 0, fetch_count = 0, fetch_limit = 0, rom_waits = 0, mem_waits = 0;
    int rom_cnt = 0, mem_cnt = 0, mem_held = 0, last_wr_held = 0, park_cycle = 0;
    bit parked = 1'b0;
    bit            h_we;
    logic [AW-1:0] h_addr;
    logic [N-1:0]  h_wdata;

    // Responder: decides acks at the falling edge from the registered requests.
    always @(negedge clk) begin
        mem_op_t e;
        cyc++;
        rom_ack = 1'b0;
        if (rom_req) begin
            if (fetch_count >= fetch_limit) begin
                if (!parked) begin
                    parked = 1'b1;
                    park_cycle = cyc;
                end
            end else if (rom_cnt < rom_waits) begin
                rom_cnt++;
            end else begin
                rom_ack = 1'b1;
                rom_data = rom[rom_addr];
                rom_cnt = 0;
                fetch_count++;
                $display("fetch pc=0x%04h instr=0x%04h cycle=%0d", rom_addr, rom_data, cyc);
            end
        end else begin
            rom_cnt = 0;
        end

        mem_ack = 1'b0;
        if (mem_req) begin
            if (mem_held == 0) begin
                h_we = mem_we;
                h_addr = mem_addr;
                h_wdata = mem_wdata;
            end else begin
                check("mem_hold_addr", 32'(mem_addr), 32'(h_addr));
                check("mem_hold_we", 32'(mem_we), 32'(h_we));
                if (h_we) check("mem_hold_wdata", 32'(mem_wdata), 32'(h_wdata));
            end
            mem_held++;
            if (mem_cnt < mem_waits) begin
                mem_cnt++;
            end else begin
                mem_ack = 1'b1;
                mem_cnt = 0;
                if (mem_we) begin
                    ram[mem_addr] = mem_wdata;
                    last_wr_held = mem_held;
                end else begin
                    mem_rdata = ram[mem_addr];
                end
                $display("mem %s addr=%0d data=0x%04h held=%0d", mem_we ? "wr" : "rd", mem_addr,
                         mem_we ? mem_wdata : mem_rdata, mem_held);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: got access at addr %0d, expected none", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.data));
                end
                mem_held = 0;
            end
        end else begin
            mem_cnt = 0;
            mem_held = 0;
        end
    end

    task automatic start_run(input int lim, input int rw, input int mw);
        rst = 1'b1;
        @(posedge clk); #1;
        fetch_limit = lim; rom_waits = rw; mem_waits = mw;
        fetch_count = 0; parked = 1'b0; park_cycle = 0;
        rom_cnt = 0; mem_cnt = 0; mem_held = 0; last_wr_held = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_park(input string name, input int budget);
        int n = 0;
        while (!parked && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check({name, "_parked"}, 32'(parked), 32'd1);
    endtask

    task automatic push_op(input bit we, input logic [AW-1:0] addr, input logic [N-1:0] data);
        mem_op_t e;
        e.we = we; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    typedef struct {
        string         name;
        int            n;
        logic [N-1:0]  p0, p1, p2;
        int            rw;
        int            cycles;
        logic [AW-1:0] pc;
        logic [N-1:0]  a, d;
    } vec_t;

    function automatic vec_t mk(input string nm, input int n, input logic [N-1:0] p0, p1, p2,
                                input int rw, input int cy, input logic [AW-1:0] vpc,
                                input logic [N-1:0] va, vd);
        vec_t v;
        v.name = nm; v.n = n; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.rw = rw;
        v.cycles = cy; v.pc = vpc; v.a = va; v.d = vd;
        return v;
    endfunction

    vec_t vecs[7];

    initial begin
        // cycles = index of the parked fetch cycle after reset release
        vecs[0] = mk("a_then_da",   2, 16'h0005, 16'hEC10, 16'h0000, 0,  7, 15'd2, 16'd5, 16'd5);
        vecs[1] = mk("da_romwait",  2, 16'h0005, 16'hEC10, 16'h0000, 2, 11, 15'd2, 16'd5, 16'd5);
        vecs[2] = mk("jeq_taken",   3, 16'h0007, 16'hEA90, 16'hE302, 0, 11, 15'd7, 16'd7, 16'h0000);
        vecs[3] = mk("jgt_zero",    3, 16'h0007, 16'hEA90, 16'hE301, 0, 11, 15'd3, 16'd7, 16'h0000);
        vecs[4] = mk("jlt_taken",   3, 16'h0007, 16'hEE90, 16'hE304, 0, 11, 15'd7, 16'd7, 16'hFFFF);
        vecs[5] = mk("jgt_neg",     3, 16'h0007, 16'hEE90, 16'hE301, 0, 11, 15'd3, 16'd7, 16'hFFFF);
        vecs[6] = mk("jmp_uncond",  2, 16'h0009, 16'hEA87, 16'h0000, 0,  7, 15'd9, 16'd9, 16'h0000);

        // Reset state
        rst = 1'b1;
        @(posedge clk); #2;
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_d", 32'(alu_a), 32'd0);
        check("rst_a", 32'(alu_b), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);

        for (int i = 0; i < 7; i++) begin
            rom[0] = vecs[i].p0; rom[1] = vecs[i].p1; rom[2] = vecs[i].p2;
            start_run(vecs[i].n, vecs[i].rw, 0);
            if (i == 0) begin
                #1;
                check("rom_req_after_release", 32'(rom_req), 32'd1);
                check("rom_addr_after_release", 32'(rom_addr), 32'd0);
            end
            wait_park(vecs[i].name, 100);
            check({vecs[i].name, "_cycles"}, 32'(park_cycle), 32'(vecs[i].cycles));
            check({vecs[i].name, "_pc"}, 32'(pc), 32'(vecs[i].pc));
            check({vecs[i].name, "_a"}, 32'(alu_b), 32'(vecs[i].a));
            check({vecs[i].name, "_d"}, 32'(alu_a), 32'(vecs[i].d));
            check({vecs[i].name, "_halted"}, 32'(halted), 32'd0);
            $display("vector %s pc=0x%04h a=0x%04h d=0x%04h cycles=%0d", vecs[i].name, pc, alu_b, alu_a, park_cycle);
        end

        // M=D+1 with D=5, A=100 and three wait states on the write
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7C8;
        push_op(1'b1, 15'd100, 16'd6);
        start_run(4, 0, 3);
        wait_park("mwrite", 100);
        check("mwrite_cycles", 32'(park_cycle), 32'd17);
        check("mwrite_held", 32'(last_wr_held), 32'd4);
        check("mwrite_pc", 32'(pc), 32'd4);
        check("mwrite_a", 32'(alu_b), 32'd100);
        check("mwrite_d", 32'(alu_a), 32'd5);
        check("mwrite_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // AM=M-1 at 200, RAM holds 0x1234, two waits per access
        rom[0] = 16'h00C8; rom[1] = 16'hFCA8;
        ram[200] = 16'h1234;
        push_op(1'b0, 15'd200, 16'h0000);
        push_op(1'b1, 15'd200, 16'h1233);
        start_run(2, 0, 2);
        wait_park("amdec", 100);
        check("amdec_cycles", 32'(park_cycle), 32'd13);
        check("amdec_a", 32'(mem_addr), 32'h1233);
        check("amdec_d", 32'(alu_a), 32'd0);
        check("amdec_pc", 32'(pc), 32'd2);
        check("amdec_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // PC wraps from 0x7FFF to 0
        rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[15'h7FFF] = 16'h0003;
        start_run(3, 0, 0);
        wait_park("wrap", 100);
        check("wrap_cycles", 32'(park_cycle), 32'd9);
        check("wrap_pc", 32'(pc), 32'd0);
        check("wrap_a", 32'(alu_b), 32'd3);

        // ALU error halts with nothing committed
        rom[0] = 16'h0009; rom[1] = 16'hEC10; rom[2] = 16'hE818;
        start_run(5, 0, 0);
        repeat (30) begin @(posedge clk); #2; end
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_rom_req", 32'(rom_req), 32'd0);
        check("halt_mem_req", 32'(mem_req), 32'd0);
        check("halt_fetches", 32'(fetch_count), 32'd3);
        check("halt_pc", 32'(pc), 32'd2);
        check("halt_a", 32'(alu_b), 32'd9);
        check("halt_d", 32'(alu_a), 32'd9);
        rst = 1'b1;
        #1;
        check("halt_cleared_by_reset", 32'(halted), 32'd0);
        $display("halt test pc=0x%04h fetches=%0d", pc, fetch_count);

        // Reset during a pending write drops the request immediately
        rom[0] = 16'h0064; rom[1] = 16'hE7C8;
        start_run(2, 0, 50);
        begin
            int n = 0;
            while (!mem_req && n < 50) begin @(posedge clk); #1; n++; end
        end
        check("midrst_req_seen", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_rom_req", 32'(rom_req), 32'd0);
        check("midrst_pc", 32'(pc), 32'd0);
        @(posedge clk); #2;
        check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hack_cpu_seq.md
# hack_cpu_seq

Multi-cycle sequencer for the Hack CPU.
- Owns the A, D, PC and instruction registers.
- Fetches each instruction over a handshaked ROM port and decodes A-/C-instructions.
- Drives the shared combinational ALU's operands and six control bits.
- Performs data-memory reads and writes over a handshaked RAM port, then commits results and jumps.
- Sits between the instruction ROM, data RAM and the ALU in the CPU top level.

## Interface
- N, 16, data/register width
- AW, 15, ROM/RAM address width (AW < N)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- o_rom_req  out  1  instruction fetch request
- o_rom_addr  out  AW  fetch address, equals PC
- i_rom_ack  in  1  fetch complete; i_rom_data valid this cycle
- i_rom_data  in  N  instruction word
- o_mem_req  out  1  data memory request
- o_mem_we  out  1  1 = write, 0 = read
- o_mem_addr  out  AW  A[AW-1:0]
- o_mem_wdata  out  N  registered ALU result
- i_mem_ack  in  1  access complete; i_mem_rdata valid on reads
- i_mem_rdata  in  N  read data
- o_alu_a  out  N  ALU operand x = D
- o_alu_b  out  N  ALU operand y = IR[12] ? MDR : A
- o_alu_ctl  out  6  {zx,nx,zy,ny,f,no} = IR[11:6]
- i_alu_res  in  N  ALU result
- i_alu_err  in  1  ALU unsupported-opcode flag
- o_pc  out  AW  current PC
- o_halted  out  1  sticky halt after ALU error

## Operation
- States: FETCH, DECODE, MEMRD, EXEC, MEMWR, WB, HALT.
- FETCH:
  - o_rom_req=1.
  - On i_rom_ack: IR<=i_rom_data, then DECODE.
- DECODE:
  - IR[15]=0 (A-instruction): A<={0,IR[14:0]} zero-extended to N; PC<=PC+1; then FETCH.
  - IR[15]=1 (C-instruction): go to MEMRD if IR[12]=1, else EXEC. Bits IR[14:13] are ignored.
- MEMRD:
  - o_mem_req=1, o_mem_we=0.
  - On i_mem_ack: MDR<=i_mem_rdata, then EXEC.
- EXEC:
  - Sample i_alu_res into R.
  - zr = (i_alu_res==0); ng = i_alu_res[N-1].
  - jump = (j2&ng) | (j1&zr) | (j0&~ng&~zr), with j = IR[2:0].
  - If i_alu_err=1: go to HALT with no register or memory update.
  - Else go to MEMWR if IR[3]=1, otherwise WB.
- MEMWR:
  - o_mem_req=1, o_mem_we=1, o_mem_wdata=R.
  - On i_mem_ack: go to WB.
- WB:
  - If IR[5]: A<=R. If IR[4]: D<=R.
  - PC<=jump ? A_old[AW-1:0] : PC+1, where A_old is the value of A before this cycle's update.
  - Then FETCH.
- HALT: all requests low, registers frozen, o_halted=1. Only reset exits HALT.
- o_mem_addr always uses A before writeback, so an AM= write goes to the old A.
- PC+1 wraps 2^AW-1 -> 0.
- o_alu_ctl and o_alu_b are driven combinationally from IR, A, D and MDR in every state. They are valid and stable throughout EXEC.

## Timing
- Reset values: state=FETCH, PC=0, A=0, D=0, IR=0, MDR=0, R=0.
- Reset output values: o_halted=0, o_rom_req=0 while i_rst=1, o_mem_req=0, o_mem_we=0.
- o_rom_req rises in the first cycle after i_rst deasserts.
- Requests are decoded from state only. Once asserted, a request and its address/data are held constant until ack is sampled high.
- Ack is allowed in the same cycle the request rises (zero wait). Ack while no request is pending is ignored.
- Latency with zero-wait acks:
  - A-instruction: 2 cycles.
  - C-instruction without memory access: 4 cycles.
  - Add +1 cycle for an M read and +1 for an M write.
  - Each wait cycle adds 1.
- Reset asserted mid-transaction takes effect immediately. Requests drop in the same cycle, and in-flight accesses are abandoned.

## Test plan
- Reset then release, ROM acks immediately -> o_rom_addr=0; o_rom_req=1 in the first cycle after release; no o_mem_req.
- Program @5 (0x0005) then D=A (0xEC10) with zero-wait ROM -> A=5 and D=5 after 6 cycles; PC=2.
- @100 then M=D+1 (0xE7C8) with D=5 and 3 wait cycles on write ack -> write addr 100, wdata 6, held stable 4 cycles; D and A unchanged.
- @7; D;JEQ with D=0 -> PC=7. Same with JGT -> PC=prior+1. D=-1 with JLT -> PC=7.
- @200; AM=M-1 (0xFCA8), RAM returns 0x1234 after 2 waits -> read then write at addr 200, wdata 0x1233; A=0x1233 afterwards.
- C-instruction with c=100000 and i_alu_err=1 -> o_halted=1; no o_mem_req; PC, A, D frozen until reset.
- PC=0x7FFF running an A-instruction -> PC wraps to 0.
